mux_rr_pipe: RTL and testbench

- Parametrised, registered successor to the fixed 16:1 bit mux.
- Selects one of CHANNELS words of WIDTH bits and registers it into a single output stage with valid/ready handshake.
- Two modes: direct select (sel port) or round-robin scan over requesting channels.
- Sits between multiple producer channels and one downstream consumer.

---
 rtl/mux_rr_pipe_if.sv | 42 ++++
 rtl/mux_rr_pipe.sv | 118 +++++++++++
 tb/tb_mux_rr_pipe.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mux_rr_pipe_if.sv
// Channel-side and consumer-side bundle for mux_rr_pipe.
// slave faces the mux; master faces producers and the consumer.
interface mux_rr_pipe_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 16
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [SEL_W-1:0]          sel;
    logic                      mode;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_valid;
    logic                      out_ready;

    modport slave (
        input  in_data,
        input  in_valid,
        input  sel,
        input  mode,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_chan,
        output out_valid
    );

    modport master (
        output in_data,
        output in_valid,
        output sel,
        output mode,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_chan,
        input  out_valid
    );
endinterface

// File: rtl/mux_rr_pipe.sv
// Registered CHANNELS:1 word mux, direct or round-robin select.
// MUX_RR_PIPE_SELERR_EN adds a sticky out-of-range select flag.
module mux_rr_pipe #(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 16,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic            clk,
    input  logic            rst,
`ifdef MUX_RR_PIPE_SELERR_EN
    mux_rr_pipe_if.slave    bus,
    output logic            sel_err
`else
    mux_rr_pipe_if.slave    bus
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] scan_cand;
    logic             scan_hit;
    logic [SEL_W-1:0] cand;
    logic             cand_hit;
    logic             sel_ok;
    logic             dir_hit;
    logic             can_load;
    logic             grant;
    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] chan_q;

    assign sel_ok   = int'(bus.sel) < CHANNELS;
    assign dir_hit  = sel_ok && bus.in_valid[bus.sel];
    assign can_load = (state == EMPTY) || bus.out_ready;

    // First requester strictly after the last granted channel, wrapping.
    always_comb begin
        int j;
        j         = 0;
        scan_hit  = 1'b0;
        scan_cand = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            j = int'(rr_ptr) + 1 + i;
            if (j >= CHANNELS) j = j - CHANNELS;
            if (!scan_hit && bus.in_valid[SEL_W'(j)]) begin
                scan_hit  = 1'b1;
                scan_cand = SEL_W'(j);
            end
        end
    end

    always_comb begin
        cand     = bus.sel;
        cand_hit = dir_hit;
        if (bus.mode) begin
            cand     = scan_cand;
            cand_hit = scan_hit;
        end
    end

    // A grant during reset would be dropped, so never offer one.
    assign grant = !rst && can_load && cand_hit;

    always_comb begin
        bus.in_ready = '0;
        if (grant) bus.in_ready[cand] = 1'b1;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            EMPTY: if (grant) state_nx = FULL;
            FULL:  if (bus.out_ready && !grant) state_nx = EMPTY;
            default: state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            chan_q <= '0;
            rr_ptr <= SEL_W'(CHANNELS - 1);
        end else if (grant) begin
            data_q <= bus.in_data[int'(cand)*WIDTH +: WIDTH];
            chan_q <= cand;
            if (bus.mode) rr_ptr <= cand;
        end
    end

    assign bus.out_valid = (state == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_chan  = chan_q;

`ifdef MUX_RR_PIPE_SELERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err <= 1'b0;
        end else if (!bus.mode && !sel_ok &&
                     (|bus.in_valid) && can_load) begin
            sel_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mux_rr_pipe.sv
// Directed bench for mux_rr_pipe: 16-channel vector table plus
// a hand-written 6-channel sequence for non-power-of-two indices.
module tb_mux_rr_pipe;

    logic clk;
    logic rst;
    logic rst6;
    int   tests;
    int   fails;

    mux_rr_pipe_if #(.WIDTH(8), .CHANNELS(16)) bus16 ();
    mux_rr_pipe_if #(.WIDTH(8), .CHANNELS(6))  bus6 ();

`ifdef MUX_RR_PIPE_SELERR_EN
    logic sel_err16;
    logic sel_err6;
`endif

    mux_rr_pipe #(.WIDTH(8), .CHANNELS(16)) dut16 (
        .clk     (clk),
        .rst     (rst),
`ifdef MUX_RR_PIPE_SELERR_EN
        .sel_err (sel_err16),
`endif
        .bus     (bus16)
    );

    mux_rr_pipe #(.WIDTH(8), .CHANNELS(6)) dut6 (
        .clk     (clk),
        .rst     (rst6),
`ifdef MUX_RR_PIPE_SELERR_EN
        .sel_err (sel_err6),
`endif
        .bus     (bus6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        mode;
        logic [3:0]  sel;
        logic [15:0] iv;
        logic        ordy;
        logic [15:0] eir;
        logic        ev;
        logic [7:0]  ed;
        logic [3:0]  ec;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rs, input logic md, input logic [3:0] sl,
        input logic [15:0] iv, input logic ordy,
        input logic [15:0] eir, input logic ev,
        input logic [7:0] ed, input logic [3:0] ec
    );
        vec_t v;
        v.rst = rs;  v.mode = md;  v.sel = sl;
        v.iv  = iv;  v.ordy = ordy;
        v.eir = eir; v.ev = ev; v.ed = ed; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step6(
        input logic md, input logic [2:0] sl, input logic [5:0] iv,
        input logic ordy, input logic [5:0] eir, input logic ev,
        input logic [7:0] ed, input logic [2:0] ec, input string nm
    );
        @(negedge clk);
        bus6.mode      = md;
        bus6.sel       = sl;
        bus6.in_valid  = iv;
        bus6.out_ready = ordy;
        #1;
        chk({nm, ".in_ready"}, 32'(bus6.in_ready), 32'(eir));
        @(posedge clk);
        #1;
        chk({nm, ".out_valid"}, 32'(bus6.out_valid), 32'(ev));
        if (ev) begin
            chk({nm, ".out_data"}, 32'(bus6.out_data), 32'(ed));
            chk({nm, ".out_chan"}, 32'(bus6.out_chan), 32'(ec));
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        rst6  = 1'b1;
        for (int k = 0; k < 16; k++)
            bus16.in_data[k*8 +: 8] = 8'hA0 | 8'(k);
        for (int k = 0; k < 6; k++)
            bus6.in_data[k*8 +: 8] = 8'h50 | 8'(k);
        bus16.in_valid = '0; bus16.sel = '0;
        bus16.mode = 1'b0;   bus16.out_ready = 1'b0;
        bus6.in_valid = '0;  bus6.sel = '0;
        bus6.mode = 1'b0;    bus6.out_ready = 1'b0;

        // rst, mode, sel, in_valid, out_ready | in_ready, valid, data, chan
        vecs.push_back(mk(1,0,5,16'h0020,1, 16'h0000,0,8'h00,0));
        vecs.push_back(mk(0,0,5,16'h0020,1, 16'h0020,1,8'hA5,5));
        vecs.push_back(mk(0,1,0,16'h8101,1, 16'h0001,1,8'hA0,0));
        vecs.push_back(mk(0,1,0,16'h8101,1, 16'h0100,1,8'hA8,8));
        vecs.push_back(mk(0,1,0,16'h8101,1, 16'h8000,1,8'hAF,15));
        vecs.push_back(mk(0,1,0,16'h8101,1, 16'h0001,1,8'hA0,0));
        vecs.push_back(mk(0,1,0,16'h0004,0, 16'h0000,1,8'hA0,0));
        vecs.push_back(mk(0,1,0,16'h0004,0, 16'h0000,1,8'hA0,0));
        vecs.push_back(mk(0,1,0,16'h0004,0, 16'h0000,1,8'hA0,0));
        vecs.push_back(mk(0,0,5,16'h0020,0, 16'h0000,1,8'hA0,0));
        vecs.push_back(mk(0,1,0,16'h0004,1, 16'h0004,1,8'hA2,2));
        vecs.push_back(mk(0,0,3,16'h0004,1, 16'h0000,0,8'hA2,2));
        vecs.push_back(mk(0,0,3,16'h0008,0, 16'h0008,1,8'hA3,3));
        vecs.push_back(mk(0,0,3,16'h0000,1, 16'h0000,0,8'hA3,3));
        vecs.push_back(mk(0,1,0,16'h0000,1, 16'h0000,0,8'hA3,3));
        vecs.push_back(mk(0,1,0,16'h0080,1, 16'h0080,1,8'hA7,7));
        vecs.push_back(mk(1,1,0,16'h0301,0, 16'h0000,0,8'h00,0));
        vecs.push_back(mk(0,1,0,16'h0301,1, 16'h0001,1,8'hA0,0));
        vecs.push_back(mk(0,1,0,16'h0301,1, 16'h0100,1,8'hA8,8));

        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst             = vecs[i].rst;
            bus16.mode      = vecs[i].mode;
            bus16.sel       = vecs[i].sel;
            bus16.in_valid  = vecs[i].iv;
            bus16.out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d.in_ready", i),
                32'(bus16.in_ready), 32'(vecs[i].eir));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.out_valid", i),
                32'(bus16.out_valid), 32'(vecs[i].ev));
            chk($sformatf("v%0d.out_data", i),
                32'(bus16.out_data), 32'(vecs[i].ed));
            chk($sformatf("v%0d.out_chan", i),
                32'(bus16.out_chan), 32'(vecs[i].ec));
        end

        // Six channels: out-of-range select, then scan wrap at 5 -> 0.
        @(negedge clk);
        rst6 = 1'b0;
        step6(0, 3'd7, 6'h3F, 1, 6'h00, 0, 8'h00, 0, "c6_sel7");
`ifdef MUX_RR_PIPE_SELERR_EN
        chk("c6_sel_err_set", 32'(sel_err6), 32'd1);
`endif
        step6(0, 3'd2, 6'h3F, 1, 6'h04, 1, 8'h52, 2, "c6_sel2");
`ifdef MUX_RR_PIPE_SELERR_EN
        chk("c6_sel_err_sticky", 32'(sel_err6), 32'd1);
        chk("c16_sel_err_clear", 32'(sel_err16), 32'd0);
`endif
        step6(1, 3'd0, 6'h21, 1, 6'h01, 1, 8'h50, 0, "c6_scan0");
        step6(1, 3'd0, 6'h21, 1, 6'h20, 1, 8'h55, 5, "c6_scan5");
        step6(1, 3'd0, 6'h21, 1, 6'h01, 1, 8'h50, 0, "c6_wrap0");
        step6(1, 3'd0, 6'h00, 1, 6'h00, 0, 8'h50, 0, "c6_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
